uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with an integrated receive FIFO, the successor to the single-byte UART front end. It oversamples `uart_rx` at `CLKS_PER_BIT` clocks per bit, reassembles `DATA_BITS`-bit frames, and buffers up to `FIFO_DEPTH` words so a slow downstream consumer (the control-interface decoder) can stall without losing characters. It also reports framing and overrun errors, and parity errors when parity is compiled in.

## Interface
- `CLKS_PER_BIT`, 16, clocks per UART bit; minimum 4.
- `DATA_BITS`, 8, data bits per frame, 5..9, sent LSB first.
- `FIFO_DEPTH`, 4, receive FIFO entries; power of two, minimum 2.

- `clk`  in  1  single clock domain; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `uart_rx`  in  1  asynchronous serial line; idles high.
- `data_rx`  out  `DATA_BITS`  FIFO head word; valid only while `uart_valid` is high.
- `uart_valid`  out  1  FIFO not empty.
- `uart_ready`  in  1  consumer accepts the head word.
- `fifo_level`  out  clog2(`FIFO_DEPTH`)+1  number of stored words.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch. Tied 0 when parity is not compiled in.
- `overrun`  out  1  one-cycle pulse: a good frame was dropped because the FIFO was full.

## Operation
- Input path: `uart_rx` passes through a 2-flop synchroniser before any use. The synchroniser flops reset to 1.
- States:
  - IDLE: wait for a falling edge on the synchronised line, then go to START and clear the bit-clock counter.
  - START: at count `CLKS_PER_BIT/2 - 1`, sample the line. If high, it is a false start: return to IDLE. If low, go to DATA with the bit index at 0.
  - DATA: sample every `CLKS_PER_BIT` clocks (mid-bit) and shift in LSB first. After `DATA_BITS` samples, go to PARITY if compiled in, otherwise STOP.
  - PARITY: one mid-bit sample, then go to STOP.
  - STOP: one mid-bit sample, then go to IDLE immediately at mid-stop, so the receiver resynchronises on the next falling edge.
- Frame result at the stop sample:
  - Stop bit = 0: pulse `frame_err` and discard the word.
  - Parity mismatch: pulse `parity_err` and discard the word.
  - Both wrong: both pulses fire and the word is discarded.
  - Otherwise: push the word.
- FIFO: first-word fall-through. `data_rx` is the head word; `uart_valid` is `fifo_level != 0`.
  - Pop happens when `uart_valid && uart_ready`.
  - `uart_ready` while empty is ignored.
- Push while full:
  - Without a pop in the same cycle: the new word is dropped, `overrun` pulses, and the stored contents are unchanged.
  - With a pop in the same cycle: the push succeeds and the level stays at `FIFO_DEPTH`.
- Push and pop in the same cycle at any other level: the level is unchanged.
- Pointers wrap modulo `FIFO_DEPTH`. The level saturates at neither end illegally.

## Timing
- Reset values: `uart_valid`=0, `fifo_level`=0, `data_rx`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, state=IDLE, FIFO pointers=0.
- A reset in mid-frame aborts the frame and empties the FIFO. The receiver then waits for a fresh falling edge, so a frame in progress is not picked up mid-stream.
- Detection latency: 2 synchroniser clocks plus 1 edge-detect clock from the line falling edge to START entry.
- The push happens in the clock after the stop-bit sample. `uart_valid` rises in the next cycle and `data_rx` is stable in that same cycle.
- Pop: `fifo_level` and the head word update in the cycle after the handshake. If `FIFO_DEPTH` words are pending, back-to-back pops (ready held high) drain one word per clock.
- Error pulses are aligned to the cycle in which the push would have occurred.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: a parity bit follows the data bits. Even parity is checked; the XOR over data and parity bits must be 0. A frame is `DATA_BITS`+3 bit times long.
  - Undefined: no PARITY state, `parity_err` is tied 0, and a frame is `DATA_BITS`+2 bit times long.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and a 10 ns clock (160 ns bits), except where a scenario sets its own parameters.
- Single frame 0x55 with ready held low: `uart_valid` rises with `data_rx`=0x55 and `fifo_level`=1. A one-cycle ready pulse then gives `uart_valid`=0 and `fifo_level`=0.
- Frames 0x0F, 0x31 ('1'), 0x32 ('2'), 0xAD back-to-back with ready low (`FIFO_DEPTH`=4): `fifo_level`=4. Holding ready high then pops 0x0F, 0x31, 0x32, 0xAD on consecutive clocks.
- Five frames with ready low and `FIFO_DEPTH`=4: `overrun` pulses once, at the fifth frame. The FIFO still holds the first four words in order.
- Frame 0x3C with the stop bit forced low: `frame_err` pulses once and `fifo_level` stays 0. A following normal frame 0x41 is received correctly.
- A 48 ns low glitch on an idle line: the receiver returns to IDLE with no push and no error pulse. With `UART_RX_PARITY_EN` defined, frame 0x07 with parity bit 0 asserts `parity_err`; the same frame with parity bit 1 is accepted.
- `rst` asserted mid-data-bit after two words are buffered: all outputs return to their reset values the next cycle. The remainder of the interrupted frame produces no push.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a first-word
// fall-through receive FIFO, with framing / parity / overrun reporting.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after data).
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  output logic [DATA_BITS-1:0]          data_rx,
  output logic                          uart_valid,
  input  logic                          uart_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [1:0]    SETTLE_END = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Synchroniser and edge detection
  logic          r_rx_meta;
  logic          r_rx_sync;
  logic          r_rx_prev;
  logic [1:0]    r_settle_cnt;
  logic          r_idle_seen;
  logic          w_fall;

  // Receive FSM and bit datapath
  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_clk_cnt;
  logic [BW-1:0]         r_bit_idx;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  w_half_tick;
  logic                  w_bit_tick;
  logic                  w_cnt_clr;
  logic                  w_take_data;
  logic                  w_take_stop;
  logic                  w_par_bad;

  // Frame result, valid for the single cycle after the stop sample
  logic                  r_word_good;
  logic                  r_frame_err;

  // FIFO
  logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;

  // Two-flop synchroniser plus a one-clock delayed copy for falling-edge
  // detection. After reset the receiver must see the settled line high
  // before it arms, so a frame interrupted by reset is never joined midway.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta    <= 1'b1;
      r_rx_sync    <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_settle_cnt <= 2'd0;
      r_idle_seen  <= 1'b0;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      if (r_settle_cnt != SETTLE_END) begin
        r_settle_cnt <= r_settle_cnt + 2'd1;
      end
      if ((r_settle_cnt == SETTLE_END) && r_rx_sync) begin
        r_idle_seen <= 1'b1;
      end
    end
  end

  assign w_fall      = r_idle_seen && r_rx_prev && !r_rx_sync;
  assign w_half_tick = (r_clk_cnt == CNT_HALF);
  assign w_bit_tick  = (r_clk_cnt == CNT_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_half_tick) begin
          w_state_next = r_rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_tick && (r_bit_idx == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
          w_state_next = S_PARITY;
`else
          w_state_next = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_bit_tick) begin
          w_state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_tick) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic w_take_parity;
`endif

  // FSM outputs: counter restart and sample strobes
  always_comb begin
    w_cnt_clr   = 1'b0;
    w_take_data = 1'b0;
    w_take_stop = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_take_parity = 1'b0;
`endif
    unique case (r_state)
      S_IDLE:   w_cnt_clr = 1'b1;
      S_START:  w_cnt_clr = w_half_tick;
      S_DATA: begin
        w_cnt_clr   = w_bit_tick;
        w_take_data = w_bit_tick;
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        w_cnt_clr     = w_bit_tick;
        w_take_parity = w_bit_tick;
      end
`endif
      S_STOP: begin
        w_cnt_clr   = w_bit_tick;
        w_take_stop = w_bit_tick;
      end
      default: w_cnt_clr = 1'b1;
    endcase
  end

  // Bit-clock counter, data bit index and LSB-first shift register.
  // The shift register is left untouched in IDLE so the FIFO can write
  // it in the cycle after the stop sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_clk_cnt <= w_cnt_clr ? '0 : r_clk_cnt + CW'(1);
      if (w_take_data) begin
        r_shift   <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
        r_bit_idx <= r_bit_idx + BW'(1);
      end else if (r_state != S_DATA) begin
        r_bit_idx <= '0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;

  // Capture the received parity bit at its mid-bit sample
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par_bit <= 1'b0;
    end else if (w_take_parity) begin
      r_par_bit <= r_rx_sync;
    end
  end

  // Even parity: XOR over data and parity bit must be zero
  assign w_par_bad = ^{r_shift, r_par_bit};

  // Parity error pulse, aligned with the would-be push cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_take_stop && w_par_bad;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Frame verdict at the stop sample; both flags are single-cycle pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_good <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_word_good <= w_take_stop && r_rx_sync && !w_par_bad;
      r_frame_err <= w_take_stop && !r_rx_sync;
    end
  end

  assign frame_err = r_frame_err;

  // FIFO control: a full FIFO still accepts a push when a pop frees a slot
  assign w_full  = (r_level == LEVEL_FULL);
  assign w_pop   = uart_valid && uart_ready;
  assign w_push  = r_word_good && (!w_full || w_pop);
  assign overrun = r_word_good && w_full && !w_pop;

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  // FIFO pointers (natural power-of-two wrap) and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign uart_valid = (r_level != '0);
  assign fifo_level = r_level;
  // Head word is forced to zero while empty so it reads 0 out of reset
  assign data_rx    = uart_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo (CLKS_PER_BIT=16, 8 data bits,
// 4-entry FIFO). Frames are driven bit by bit on the falling clock edge.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic       uart_rx;
  logic [7:0] data_rx;
  logic       uart_valid;
  logic       uart_ready;
  logic [2:0] fifo_level;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int checks;
  int errors;
  int n_ferr;
  int n_perr;
  int n_ovr;

  uart_rx_fifo #(
    .CLKS_PER_BIT (16),
    .DATA_BITS    (8),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .data_rx    (data_rx),
    .uart_valid (uart_valid),
    .uart_ready (uart_ready),
    .fifo_level (fifo_level),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (frame_err)  n_ferr++;
    if (parity_err) n_perr++;
    if (overrun)    n_ovr++;
  end

  task automatic drive_bit(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_v, 16);
`else
    if (par_v === 1'bx) $display("note: parity bit unknown");
`endif
    drive_bit(stop_v, 16);
    uart_rx = 1'b1;
  endtask

  task automatic check_head(input string name, input logic v, input logic [7:0] d, input logic [2:0] lvl);
    checks++;
    if (uart_valid !== v || data_rx !== d || fifo_level !== lvl) begin
      errors++;
      $display("FAIL %s: valid=%0b data=%02h level=%0d, expected valid=%0b data=%02h level=%0d",
               name, uart_valid, data_rx, fifo_level, v, d, lvl);
    end else begin
      $display("ok   %s: valid=%0b data=%02h level=%0d", name, uart_valid, data_rx, fifo_level);
    end
  endtask

  task automatic pop_one();
    uart_ready = 1'b1;
    @(negedge clk);
    uart_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; uart_rx = 1'b1; uart_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_head("reset_head", 1'b0, 8'h00, 3'd0);
    checks++;
    if ({frame_err, parity_err, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses: got %03b, expected 000", {frame_err, parity_err, overrun});
    end else $display("ok   reset_pulses: 000");
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single();
    send_frame(8'h55, 1'b1, ^8'h55);
    check_head("single_55", 1'b1, 8'h55, 3'd1);
    pop_one();
    check_head("single_pop", 1'b0, 8'h00, 3'd0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [4];
    exp_q = '{8'h0F, 8'h31, 8'h32, 8'hAD};
    for (int i = 0; i < 4; i++) send_frame(exp_q[i], 1'b1, ^exp_q[i]);
    check_head("b2b_full", 1'b1, 8'h0F, 3'd4);
    uart_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("b2b_pop%0d", i), 1'b1, exp_q[i], 3'(4 - i));
      @(negedge clk);
    end
    uart_ready = 1'b0;
    check_head("b2b_empty", 1'b0, 8'h00, 3'd0);
  endtask

  task automatic test_overrun();
    logic [7:0] exp_q [5];
    int ovr0;
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99};
    ovr0 = n_ovr;
    for (int i = 0; i < 4; i++) send_frame(exp_q[i], 1'b1, ^exp_q[i]);
    checks++;
    if (n_ovr - ovr0 !== 0) begin
      errors++;
      $display("FAIL ovr_before: pulses=%0d, expected 0", n_ovr - ovr0);
    end else $display("ok   ovr_before: pulses=0");
    send_frame(exp_q[4], 1'b1, ^exp_q[4]);
    checks++;
    if (n_ovr - ovr0 !== 1) begin
      errors++;
      $display("FAIL ovr_fifth: pulses=%0d, expected 1", n_ovr - ovr0);
    end else $display("ok   ovr_fifth: pulses=1");
    uart_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("ovr_pop%0d", i), 1'b1, exp_q[i], 3'(4 - i));
      @(negedge clk);
    end
    uart_ready = 1'b0;
    check_head("ovr_empty", 1'b0, 8'h00, 3'd0);
  endtask

  task automatic test_frame_error();
    int fe0;
    fe0 = n_ferr;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    drive_bit(1'b1, 16);
    checks++;
    if (n_ferr - fe0 !== 1) begin
      errors++;
      $display("FAIL ferr_pulse: pulses=%0d, expected 1", n_ferr - fe0);
    end else $display("ok   ferr_pulse: pulses=1");
    check_head("ferr_nopush", 1'b0, 8'h00, 3'd0);
    send_frame(8'h41, 1'b1, ^8'h41);
    check_head("ferr_next_41", 1'b1, 8'h41, 3'd1);
    pop_one();
  endtask

  task automatic test_glitch();
    int fe0, pe0, ov0;
    fe0 = n_ferr; pe0 = n_perr; ov0 = n_ovr;
    uart_rx = 1'b0;
    #48;
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    check_head("glitch_nopush", 1'b0, 8'h00, 3'd0);
    checks++;
    if ((n_ferr - fe0) + (n_perr - pe0) + (n_ovr - ov0) !== 0) begin
      errors++;
      $display("FAIL glitch_pulses: pulses=%0d, expected 0", (n_ferr - fe0) + (n_perr - pe0) + (n_ovr - ov0));
    end else $display("ok   glitch_pulses: 0");
    send_frame(8'hA5, 1'b1, ^8'hA5);
    check_head("glitch_next_a5", 1'b1, 8'hA5, 3'd1);
    pop_one();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int pe0;
    pe0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b0);
    checks++;
    if (n_perr - pe0 !== 1) begin
      errors++;
      $display("FAIL perr_pulse: pulses=%0d, expected 1", n_perr - pe0);
    end else $display("ok   perr_pulse: pulses=1");
    check_head("perr_nopush", 1'b0, 8'h00, 3'd0);
    send_frame(8'h07, 1'b1, 1'b1);
    check_head("perr_good_07", 1'b1, 8'h07, 3'd1);
    pop_one();
  endtask
`endif

  task automatic test_mid_frame_reset();
    int fe0, pe0;
    send_frame(8'h12, 1'b1, ^8'h12);
    send_frame(8'h34, 1'b1, ^8'h34);
    check_head("rst_two_words", 1'b1, 8'h12, 3'd2);
    fe0 = n_ferr; pe0 = n_perr;
    // Frame 0xF0: start, bits 0 and 1, then half of bit 2, all low
    drive_bit(1'b0, 16 + 16 + 16 + 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_head("rst_head", 1'b0, 8'h00, 3'd0);
    checks++;
    if ({frame_err, parity_err, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL rst_pulses: got %03b, expected 000", {frame_err, parity_err, overrun});
    end else $display("ok   rst_pulses: 000");
    drive_bit(1'b0, 7 + 16);
    drive_bit(1'b1, 16 * 4);
`ifdef UART_RX_PARITY_EN
    drive_bit(1'b0, 16);
`endif
    drive_bit(1'b1, 16 + 40);
    check_head("rst_tail_nopush", 1'b0, 8'h00, 3'd0);
    checks++;
    if ((n_ferr - fe0) + (n_perr - pe0) !== 0) begin
      errors++;
      $display("FAIL rst_tail_pulses: pulses=%0d, expected 0", (n_ferr - fe0) + (n_perr - pe0));
    end else $display("ok   rst_tail_pulses: 0");
    send_frame(8'hC3, 1'b1, ^8'hC3);
    check_head("rst_next_c3", 1'b1, 8'hC3, 3'd1);
    pop_one();
  endtask

  initial begin
    checks = 0; errors = 0;
    n_ferr = 0; n_perr = 0; n_ovr = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_error();
    test_glitch();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_mid_frame_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
